// File: rtl/clk_div_pkg.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clock-divider controller slice.
//   state_t      : controller FSM states (IDLE / RUN / DRAIN)
//   MIN_N        : smallest legal half-period ratio; a requested 0 becomes this
//   PERIOD_CNT_W : width of the optional full-period status counter
// No ports (package).
// -----------------------------------------------------------------------------
package clk_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int MIN_N        = 1;
   localparam int PERIOD_CNT_W = 16;

endpackage

// File: rtl/clk_div_ctrl_if.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// clk_div_ctrl_if
// Ratio-configuration handshake between a requester and clk_div_ctrl.
//   cfg_n     : requested half-period ratio (WIDTH bits)
//   cfg_valid : requester offers cfg_n
//   cfg_ready : divider can accept a ratio (no ratio pending)
// Modports: master = requester side, slave = divider side.
// WIDTH must match the WIDTH of the clk_div_ctrl instance it connects to.
// -----------------------------------------------------------------------------
interface clk_div_ctrl_if #(
   parameter int WIDTH = 17
);
   logic [WIDTH-1:0] cfg_n;
   logic             cfg_valid;
   logic             cfg_ready;

   modport master (
      output cfg_n,
      output cfg_valid,
      input  cfg_ready
   );

   modport slave (
      input  cfg_n,
      input  cfg_valid,
      output cfg_ready
   );
endinterface

// File: rtl/clk_div_core.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// clk_div_core
// Half-period counter and toggle register of the divider.
//   clk     : clock (rising edge)
//   reset   : synchronous active-high reset
//   i_run   : 1 = count and toggle; 0 = hold counter at 0, div low, no tick
//   i_ratio : half-period length in clk cycles (must be >= 1)
//   o_div   : registered divided output
//   o_tick  : registered one-cycle pulse in the cycle o_div shows a new level
//   o_fall  : combinational; the coming edge will drive o_div 1->0
// -----------------------------------------------------------------------------
module clk_div_core #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_run,
   input  logic [WIDTH-1:0] i_ratio,
   output logic             o_div,
   output logic             o_tick,
   output logic             o_fall
);

   logic [WIDTH-1:0] r_cnt;
   logic             r_div;
   logic             r_tick;
   logic             w_term;

   // ">=" rather than "==" keeps the counter bounded even if the ratio were
   // ever to shrink under a running count.
   assign w_term = (r_cnt >= (i_ratio - WIDTH'(1)));
   assign o_fall = i_run & r_div & w_term;

   always_ff @(posedge clk) begin
      if (reset || !i_run) begin
         r_cnt  <= '0;
         r_div  <= 1'b0;
         r_tick <= 1'b0;
      end else if (w_term) begin
         r_cnt  <= '0;
         r_div  <= ~r_div;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + WIDTH'(1);
         r_tick <= 1'b0;
      end
   end

   assign o_div  = r_div;
   assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Glitch-free programmable clock divider producing a fabric-register divided
// signal plus a clk-domain tick (clock enable).
//   clk        : clock (rising edge)
//   reset      : synchronous active-high reset, overrides everything
//   enable     : 1 = run divided output, 0 = stop cleanly after a low phase
//   cfg        : clk_div_ctrl_if.slave (cfg_n / cfg_valid / cfg_ready)
//   div_out    : divided output (registered)
//   tick       : one-cycle pulse in the cycle div_out toggles
//   running    : high in RUN and DRAIN
//   active_n   : half-period ratio currently in effect
//   period_cnt : [only with CLK_DIV_CTRL_STATUS_EN] count of 1->0 toggles
//                since reset or last ratio change, saturating
// Optional feature macro: CLK_DIV_CTRL_STATUS_EN
// -----------------------------------------------------------------------------
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int WIDTH     = 17,
   parameter int DEFAULT_N = 50
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   clk_div_ctrl_if.slave    cfg,
   output logic             div_out,
   output logic             tick,
   output logic             running,
   output logic [WIDTH-1:0] active_n
`ifdef CLK_DIV_CTRL_STATUS_EN
   ,
   output logic [PERIOD_CNT_W-1:0] period_cnt
`endif
);

   state_t           r_state;
   logic             r_running;
   logic             r_pend;
   logic [WIDTH-1:0] r_pend_n;
   logic [WIDTH-1:0] r_active_n;

   logic             w_core_run;
   logic             w_div;
   logic             w_tick;
   logic             w_fall;
   logic             w_take;
   logic             w_apply;
   logic [WIDTH-1:0] w_cfg_clamped;

   // ---------------------------------------------------------------------------
   // Core enable. In DRAIN with div already low and enable still low the core
   // is held cleared, so a stop from a low phase can never start a new high
   // phase on its way back to IDLE.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_core_run = 1'b0;
      case (r_state)
         ST_RUN:   w_core_run = 1'b1;
         ST_DRAIN: w_core_run = w_div | enable;
         default:  w_core_run = 1'b0;
      endcase
   end

   clk_div_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .i_run   (w_core_run),
      .i_ratio (r_active_n),
      .o_div   (w_div),
      .o_tick  (w_tick),
      .o_fall  (w_fall)
   );

   // ---------------------------------------------------------------------------
   // Controller FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (enable) begin
                  r_state <= ST_RUN;
               end else if (!w_div || w_fall) begin
                  r_state   <= ST_IDLE;
                  r_running <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Ratio handshake and pending register. A ratio is only swapped in while
   // the counter is at 0 (IDLE, or the 1->0 toggle), so every phase runs its
   // full length under a single ratio. Capture needs !r_pend and apply needs
   // r_pend, so a value captured on a boundary waits for the next boundary.
   // ---------------------------------------------------------------------------
   assign cfg.cfg_ready = ~r_pend;
   assign w_take        = cfg.cfg_valid & ~r_pend;
   assign w_apply       = r_pend & ((r_state == ST_IDLE) | w_fall);
   assign w_cfg_clamped = (cfg.cfg_n == '0) ? WIDTH'(MIN_N) : cfg.cfg_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend     <= 1'b0;
         r_pend_n   <= WIDTH'(DEFAULT_N);
         r_active_n <= WIDTH'(DEFAULT_N);
      end else if (w_apply) begin
         r_active_n <= r_pend_n;
         r_pend     <= 1'b0;
      end else if (w_take) begin
         r_pend_n <= w_cfg_clamped;
         r_pend   <= 1'b1;
      end
   end

`ifdef CLK_DIV_CTRL_STATUS_EN
   // Full periods completed under the current ratio; a ratio change restarts it.
   logic [PERIOD_CNT_W-1:0] r_period_cnt;

   always_ff @(posedge clk) begin
      if (reset || w_apply) begin
         r_period_cnt <= '0;
      end else if (w_fall && (r_period_cnt != '1)) begin
         r_period_cnt <= r_period_cnt + PERIOD_CNT_W'(1);
      end
   end

   assign period_cnt = r_period_cnt;
`endif

   assign div_out  = w_div;
   assign tick     = w_tick;
   assign running  = r_running;
   assign active_n = r_active_n;

endmodule

// File: tb/tb_clk_div_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl. Each scenario pushes the toggle events
// it expects (cycle, new div_out level) into a queue; a negedge monitor pops
// one entry per observed tick and compares. Scenario tasks also check status
// outputs inline. Build with CLK_DIV_CTRL_STATUS_EN to cover period_cnt.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;
   import clk_div_pkg::*;

   localparam int WIDTH = 17;
   localparam int DEF_N = 50;

   typedef struct {
      int   cyc;
      logic val;
   } ev_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             div_out;
   logic             tick;
   logic             running;
   logic [WIDTH-1:0] active_n;
`ifdef CLK_DIV_CTRL_STATUS_EN
   logic [PERIOD_CNT_W-1:0] period_cnt;
`endif

   int  cyc   = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   ev_t exp_q[$];

   clk_div_ctrl_if #(.WIDTH(WIDTH)) cfg_if ();

   clk_div_ctrl #(
      .WIDTH     (WIDTH),
      .DEFAULT_N (DEF_N)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .cfg        (cfg_if),
      .div_out    (div_out),
      .tick       (tick),
      .running    (running),
      .active_n   (active_n)
`ifdef CLK_DIV_CTRL_STATUS_EN
      ,
      .period_cnt (period_cnt)
`endif
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; stable when read on the negedge
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every tick must match the oldest expected toggle
   always @(negedge clk) begin
      if (tick === 1'b1) begin
         ev_t ev;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL tick_unexpected cyc=%0d div_out=%0b expected no tick", cyc, div_out);
         end else begin
            ev = exp_q.pop_front();
            if (ev.cyc != cyc || div_out !== ev.val) begin
               n_bad++;
               $display("FAIL tick_event got cyc=%0d div_out=%0b expected cyc=%0d div_out=%0b",
                        cyc, div_out, ev.cyc, ev.val);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d expected end of run", cyc);
      $fatal(1, "watchdog");
   end

   task automatic push_ev(input int c, input logic v);
      ev_t ev;
      ev.cyc = c;
      ev.val = v;
      exp_q.push_back(ev);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      enable           = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_n     = '0;
      reset            = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
   endtask

   // Raise enable on the current negedge; returns the cycle RUN is entered.
   task automatic start_run(output int t0);
      enable = 1'b1;
      t0     = cyc + 1;
   endtask

   task automatic send_cfg(input int at, input logic [WIDTH-1:0] n);
      wait_cyc(at);
      cfg_if.cfg_n     = n;
      cfg_if.cfg_valid = 1'b1;
      wait_cyc(at + 1);
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (div_out !== 1'b0)  begin n_bad++; $display("FAIL rst_div got=%0b exp=0", div_out); end
      n_cmp++; if (tick !== 1'b0)     begin n_bad++; $display("FAIL rst_tick got=%0b exp=0", tick); end
      n_cmp++; if (running !== 1'b0)  begin n_bad++; $display("FAIL rst_running got=%0b exp=0", running); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%0b exp=1", cfg_if.cfg_ready); end
      n_cmp++; if (active_n !== WIDTH'(DEF_N)) begin n_bad++; $display("FAIL rst_active got=%0d exp=%0d", active_n, DEF_N); end
`ifdef CLK_DIV_CTRL_STATUS_EN
      n_cmp++; if (period_cnt !== '0) begin n_bad++; $display("FAIL rst_period got=%0d exp=0", period_cnt); end
`endif
      $display("test_reset done cyc=%0d", cyc);
   endtask

   task automatic test_default_run();
      int t0;
      do_reset();
      start_run(t0);
      for (int k = 1; k <= 4; k++) push_ev(t0 + DEF_N * k, logic'(k % 2));
      wait_cyc(t0 + 25);
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL run_running got=%0b exp=1", running); end
      n_cmp++; if (div_out !== 1'b0) begin n_bad++; $display("FAIL run_first_low got=%0b exp=0", div_out); end
      wait_cyc(t0 + 202);
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL run_missing got=%0d left exp=0", exp_q.size()); end
      $display("test_default_run done cyc=%0d", cyc);
   endtask

   task automatic test_ratio_change();
      int t0;
      do_reset();
      start_run(t0);
      push_ev(t0 + 50, 1'b1); push_ev(t0 + 100, 1'b0);
      push_ev(t0 + 110, 1'b1); push_ev(t0 + 120, 1'b0);
      push_ev(t0 + 130, 1'b1); push_ev(t0 + 140, 1'b0);
      send_cfg(t0 + 70, WIDTH'(10));
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL chg_ready_busy got=%0b exp=0", cfg_if.cfg_ready); end
      wait_cyc(t0 + 99);
      n_cmp++; if (active_n !== WIDTH'(50)) begin n_bad++; $display("FAIL chg_active_old got=%0d exp=50", active_n); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL chg_ready_hold got=%0b exp=0", cfg_if.cfg_ready); end
      wait_cyc(t0 + 100);
      n_cmp++; if (active_n !== WIDTH'(10)) begin n_bad++; $display("FAIL chg_active_new got=%0d exp=10", active_n); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL chg_ready_free got=%0b exp=1", cfg_if.cfg_ready); end
`ifdef CLK_DIV_CTRL_STATUS_EN
      n_cmp++; if (period_cnt !== '0) begin n_bad++; $display("FAIL chg_period_clr got=%0d exp=0", period_cnt); end
      wait_cyc(t0 + 121);
      n_cmp++; if (period_cnt !== PERIOD_CNT_W'(1)) begin n_bad++; $display("FAIL chg_period_inc got=%0d exp=1", period_cnt); end
`endif
      wait_cyc(t0 + 142);
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL chg_missing got=%0d left exp=0", exp_q.size()); end
      $display("test_ratio_change done cyc=%0d", cyc);
   endtask

   task automatic test_drain();
      int t0;
      do_reset();
      start_run(t0);
      push_ev(t0 + 50, 1'b1); push_ev(t0 + 100, 1'b0);
      wait_cyc(t0 + 70);
      enable = 1'b0;
      wait_cyc(t0 + 99);
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL drn_running got=%0b exp=1", running); end
      n_cmp++; if (div_out !== 1'b1) begin n_bad++; $display("FAIL drn_high got=%0b exp=1", div_out); end
      wait_cyc(t0 + 101);
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL drn_idle got=%0b exp=0", running); end
      n_cmp++; if (div_out !== 1'b0) begin n_bad++; $display("FAIL drn_low got=%0b exp=0", div_out); end
      wait_cyc(t0 + 250);
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL drn_missing got=%0d left exp=0", exp_q.size()); end
      $display("test_drain done cyc=%0d", cyc);
   endtask

   task automatic test_drain_resume();
      int t0;
      do_reset();
      start_run(t0);
      for (int k = 1; k <= 4; k++) push_ev(t0 + DEF_N * k, logic'(k % 2));
      wait_cyc(t0 + 60);
      enable = 1'b0;
      wait_cyc(t0 + 70);
      enable = 1'b1;
      wait_cyc(t0 + 71);
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL res_running got=%0b exp=1", running); end
      wait_cyc(t0 + 202);
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL res_missing got=%0d left exp=0", exp_q.size()); end
      $display("test_drain_resume done cyc=%0d", cyc);
   endtask

   task automatic test_clamp();
      int c;
      int t0;
      do_reset();
      c = cyc;
      send_cfg(c, '0);
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL clp_ready_busy got=%0b exp=0", cfg_if.cfg_ready); end
      wait_cyc(c + 3);
      n_cmp++; if (active_n !== WIDTH'(1)) begin n_bad++; $display("FAIL clp_active got=%0d exp=1", active_n); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL clp_ready_free got=%0b exp=1", cfg_if.cfg_ready); end
      start_run(t0);
      for (int k = 1; k <= 20; k++) push_ev(t0 + k, logic'(k % 2));
      wait_cyc(t0 + 5);
      n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL clp_tick got=%0b exp=1", tick); end
      wait_cyc(t0 + 12);
      n_cmp++; if (tick !== 1'b1 || div_out !== 1'b0) begin n_bad++; $display("FAIL clp_div got tick=%0b div=%0b exp tick=1 div=0", tick, div_out); end
      wait_cyc(t0 + 18);
      enable = 1'b0;
      wait_cyc(t0 + 24);
      n_cmp++; if (running !== 1'b0 || tick !== 1'b0) begin n_bad++; $display("FAIL clp_stop got run=%0b tick=%0b exp 0 0", running, tick); end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL clp_missing got=%0d left exp=0", exp_q.size()); end
      $display("test_clamp done cyc=%0d", cyc);
   endtask

   task automatic test_boundary_capture();
      int t0;
      do_reset();
      start_run(t0);
      push_ev(t0 + 50, 1'b1);  push_ev(t0 + 100, 1'b0);
      push_ev(t0 + 150, 1'b1); push_ev(t0 + 200, 1'b0);
      push_ev(t0 + 210, 1'b1); push_ev(t0 + 220, 1'b0);
      push_ev(t0 + 230, 1'b1);
      // valid seen by the same edge that drives div_out 1->0
      send_cfg(t0 + 99, WIDTH'(10));
      n_cmp++; if (active_n !== WIDTH'(50)) begin n_bad++; $display("FAIL bnd_active_kept got=%0d exp=50", active_n); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL bnd_ready got=%0b exp=0", cfg_if.cfg_ready); end
      wait_cyc(t0 + 199);
      n_cmp++; if (active_n !== WIDTH'(50)) begin n_bad++; $display("FAIL bnd_active_old got=%0d exp=50", active_n); end
      wait_cyc(t0 + 200);
      n_cmp++; if (active_n !== WIDTH'(10)) begin n_bad++; $display("FAIL bnd_active_new got=%0d exp=10", active_n); end
      wait_cyc(t0 + 232);
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bnd_missing got=%0d left exp=0", exp_q.size()); end
      $display("test_boundary_capture done cyc=%0d", cyc);
   endtask

   task automatic test_reset_pending();
      int t0;
      do_reset();
      start_run(t0);
      push_ev(t0 + 50, 1'b1); push_ev(t0 + 100, 1'b0); push_ev(t0 + 150, 1'b1);
      send_cfg(t0 + 160, WIDTH'(10));
      n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rpd_pending got=%0b exp=0", cfg_if.cfg_ready); end
      wait_cyc(t0 + 175);
      n_cmp++; if (div_out !== 1'b1) begin n_bad++; $display("FAIL rpd_high got=%0b exp=1", div_out); end
`ifdef CLK_DIV_CTRL_STATUS_EN
      n_cmp++; if (period_cnt !== PERIOD_CNT_W'(1)) begin n_bad++; $display("FAIL rpd_period_pre got=%0d exp=1", period_cnt); end
`endif
      reset  = 1'b1;
      enable = 1'b0;
      wait_cyc(t0 + 176);
      reset = 1'b0;
      n_cmp++; if (div_out !== 1'b0) begin n_bad++; $display("FAIL rpd_div got=%0b exp=0", div_out); end
      n_cmp++; if (running !== 1'b0 || tick !== 1'b0) begin n_bad++; $display("FAIL rpd_run got run=%0b tick=%0b exp 0 0", running, tick); end
      n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rpd_ready got=%0b exp=1", cfg_if.cfg_ready); end
      n_cmp++; if (active_n !== WIDTH'(DEF_N)) begin n_bad++; $display("FAIL rpd_active got=%0d exp=%0d", active_n, DEF_N); end
`ifdef CLK_DIV_CTRL_STATUS_EN
      n_cmp++; if (period_cnt !== '0) begin n_bad++; $display("FAIL rpd_period got=%0d exp=0", period_cnt); end
`endif
      wait_cyc(t0 + 180);
      n_cmp++; if (active_n !== WIDTH'(DEF_N)) begin n_bad++; $display("FAIL rpd_discard got=%0d exp=%0d", active_n, DEF_N); end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rpd_missing got=%0d left exp=0", exp_q.size()); end
      $display("test_reset_pending done cyc=%0d", cyc);
   endtask

   initial begin
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_n     = '0;
      test_reset();
      test_default_run();
      test_ratio_change();
      test_drain();
      test_drain_resume();
      test_clamp();
      test_boundary_capture();
      test_reset_pending();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
